lsu_mem_responder: RTL and testbench
====================================

// Module: lsu_mem_responder
// PURPOSE
//  Responder end of the core's load/store port: accepts LOAD/STORE requests, serves
//  them from an on-chip byte-lane RAM or the memory-mapped I/O ports, returns a response.
//  Sits between the core's LSU and memory; lane alignment and sign-extension are done here.
//  Sub-word requests use the LOAD_STORE_FNS funct3 encoding (BYTE/HALF/WORD/BYTE_U/HALF_U).
// PARAMETERS
//  MEM_WORDS     1024           RAM depth in 32-bit words; RAM occupies bytes [0, 4*MEM_WORDS)
//  OUTPORT_ADDR  32'h0000_fffc  output-port byte address (LOAD_STORE_FNS::OUTPORT_ADDR)
//  INPORT_ADDR   32'h0000_fff8  input-port byte address (LOAD_STORE_FNS::INPORT_ADDR)
//  Constraint: 4*MEM_WORDS <= INPORT_ADDR (elaboration-time assertion).
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; transfer when req_valid & req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  req_funct3  in   3   LOAD_STORE_FNS::funct3_t
//  resp_valid  out  1   response present
//  resp_ready  in   1   core accepts response; transfer when resp_valid & resp_ready
//  resp_rdata  out  32  load data, extended per funct3; 0 for stores and errors
//  resp_err    out  1   request faulted (misaligned/illegal/unmapped)
//  inport      in   32  external input port
//  outport     out  32  external output port register
// BEHAVIOUR
//  Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, outport=0, req_ready=0 while rst.
//   RAM contents not reset. Reset mid-operation abandons it; no pending write completes.
//  FSM (mem_state_t): IDLE, RD_WAIT, RESP.
//   IDLE: req_ready=1. On accept: store or fault -> RESP; load from RAM -> RD_WAIT;
//    load from port -> RESP. No accept -> stay.
//   RD_WAIT: RAM read word available; align/extend into resp_rdata -> RESP.
//   RESP: resp_valid=1, outputs held stable until resp_ready; then -> IDLE.
//   One request outstanding; req_ready=0 in RD_WAIT and RESP (no accept on handoff cycle).
//  Latency (accept edge to resp_valid): store/port load/fault 1 cycle; RAM load 2 cycles.
//  Store side effects (RAM write, outport update) commit on the accept edge only.
//  Fault, resp_err=1, no side effect, rdata=0 when: HALF/HALF_U with addr[0]!=0;
//   WORD with addr[1:0]!=0; funct3 in {011,110,111}; store with BYTE_U/HALF_U;
//   address not in RAM range and not in port words; store to INPORT_ADDR word.
//  Lanes: byte lane = addr[1:0], half lane = addr[1]; store byte-enable one-hot/pair/all;
//   store data replicated into selected lane(s). Load: BYTE/HALF sign-extend,
//   BYTE_U/HALF_U zero-extend, WORD passthrough.
//  Port words decode on addr[31:2]; sub-word accesses to outport write/read its lanes.
//   INPORT load samples inport on the accept edge. OUTPORT load returns current outport.
//  RAM index = addr[31:2] within range; addr bits above the RAM range must be zero.
// STRUCTURE
//  Package LOAD_STORE_FNS gains: INPORT_ADDR, mem_state_t enum, functions
//   store_byte_en(funct3, addr[1:0]), store_lanes(funct3, wdata), load_extend(funct3, addr[1:0], word).
//  Sub-module byte_lane_ram (DEPTH param): 4 byte-enabled write lanes, 1-cycle sync read,
//   read-during-write returns old data. Responder holds FSM, decode, fault checks, ports.
// TESTING
//  1 Reset then SW 0x12345678 @0x10, LW @0x10 -> resp_rdata=0x12345678, err=0, 2-cycle latency.
//  2 SB 0xAB @0x13, LB @0x13 -> 0xFFFFFFAB; LBU -> 0x000000AB; LW @0x10 -> 0xAB345678.
//  3 SH 0x8001 @0x22, LH -> 0xFFFF8001, LHU -> 0x00008001; LH @0x21 -> err=1, rdata=0.
//  4 SW 0xDEADBEEF @0xFFFC -> outport=0xDEADBEEF after accept edge; LW @0xFFFC returns it;
//    inport=0x55 then LW @0xFFF8 -> 0x00000055; SW @0xFFF8 -> err=1.
//  5 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0,
//    new req_valid not accepted until cycle after response handshake.
//  6 Assert rst in RD_WAIT and in RESP -> next cycle resp_valid=0, outport=0, state IDLE.

Source files
------------

// File: rtl/lsu_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_responder_pkg
// Purpose : Shared load/store definitions for the LSU memory responder:
//           funct3 sub-word encodings, port addresses, the responder state
//           enum and lane helper functions (byte-enable, store replication,
//           load alignment/extension).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package lsu_mem_responder_pkg;

    // Sub-word access encodings carried on req_funct3.
    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    localparam logic [31:0] OUTPORT_ADDR = 32'h0000_fffc;
    localparam logic [31:0] INPORT_ADDR  = 32'h0000_fff8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } mem_state_t;

    // Byte-enable for a store; zero for encodings that cannot be stored.
    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                                 input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            BYTE:    be = 4'b0001 << addr_lo;
            HALF:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data into every lane it could occupy;
    // the byte-enable then picks the real destination.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            BYTE:    lanes = {4{wdata[7:0]}};
            HALF:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Pull the addressed lane out of a word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            BYTE:    res = {{24{b[7]}}, b};
            BYTE_U:  res = {24'h0, b};
            HALF:    res = {{16{h[15]}}, h};
            HALF_U:  res = {16'h0, h};
            WORD:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_ram.sv
`default_nettype none
// ============================================================================
// Module  : byte_lane_ram
// Purpose : Single-port word RAM split into four independently writable
//           byte lanes. Synchronous one-cycle read; a read in the same cycle
//           as a write to the same word returns the old contents.
// Ports   : clk      - clock
//           i_be     - per-lane write enable
//           i_re     - read enable (registers the addressed word)
//           i_addr   - word index
//           i_wdata  - write data, lane n in bits [8n+7:8n]
//           o_rdata  - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module byte_lane_ram #(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned c_AW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [3:0]      i_be,
    input  logic            i_re,
    input  logic [c_AW-1:0] i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rdata_q;

        // Contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (i_be[g]) begin
                r_mem[i_addr] <= i_wdata[8*g +: 8];
            end
            if (i_re) begin
                r_rdata_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*g +: 8] = r_rdata_q;
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_responder
// Purpose : Responder end of the core load/store port. Accepts one LOAD or
//           STORE at a time, serves it from the byte-lane RAM or the memory
//           mapped I/O ports, and returns an aligned/extended response.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           req_valid/req_ready      - request handshake
//           req_we, req_addr,
//           req_wdata, req_funct3    - request payload
//           resp_valid/resp_ready    - response handshake
//           resp_rdata, resp_err     - response payload
//           inport                   - external input port
//           outport                  - external output port register
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] OUTPORT_ADDR = lsu_mem_responder_pkg::OUTPORT_ADDR,
    parameter logic [31:0] INPORT_ADDR  = lsu_mem_responder_pkg::INPORT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [31:0] inport,
    output logic [31:0] outport
);
    import lsu_mem_responder_pkg::*;

    localparam int unsigned c_AW = $clog2(MEM_WORDS);

    // The RAM must not overlap the port words.
    if (64'(MEM_WORDS) * 64'd4 > 64'(INPORT_ADDR)) begin : g_cfg_check
        $error("lsu_mem_responder: RAM range overlaps the I/O port words");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mem_state_t  r_state_q,  r_state_d;
    logic [31:0] r_rdata_q,  r_rdata_d;
    logic        r_err_q,    r_err_d;
    logic [31:0] r_outport_q, r_outport_d;
    logic [2:0]  r_funct3_q, r_funct3_d;
    logic [1:0]  r_lane_q,   r_lane_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_in_ram;
    logic        w_is_out;
    logic        w_is_in;
    logic        w_misaligned;
    logic        w_illegal_f3;
    logic        w_bad_store_f3;
    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_mask;
    logic [3:0]  w_ram_be;
    logic        w_ram_re;
    logic [31:0] w_ram_rdata;

    assign req_ready  = (r_state_q == IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;

    // Word-granular decode; anything above the RAM range must be zero,
    // which the magnitude compare covers for any depth.
    assign w_in_ram   = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));
    assign w_is_out   = (req_addr[31:2] == OUTPORT_ADDR[31:2]);
    assign w_is_in    = (req_addr[31:2] == INPORT_ADDR[31:2]);

    assign w_misaligned   = (((req_funct3 == HALF) || (req_funct3 == HALF_U)) && req_addr[0])
                          || ((req_funct3 == WORD) && (req_addr[1:0] != 2'b00));
    assign w_illegal_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110)
                          || (req_funct3 == 3'b111);
    assign w_bad_store_f3 = req_we && ((req_funct3 == BYTE_U) || (req_funct3 == HALF_U));

    assign w_fault = w_misaligned || w_illegal_f3 || w_bad_store_f3
                   || (!w_in_ram && !w_is_out && !w_is_in)
                   || (req_we && w_is_in);

    assign w_be    = store_byte_en(req_funct3, req_addr[1:0]);
    assign w_lanes = store_lanes(req_funct3, req_wdata);
    assign w_mask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    // RAM side effects happen only on the accept edge of a clean request.
    assign w_ram_be = (w_accept && req_we && !w_fault && w_in_ram) ? w_be : 4'b0000;
    assign w_ram_re = w_accept && !req_we && !w_fault && w_in_ram;

    byte_lane_ram #(
        .DEPTH (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_be    (w_ram_be),
        .i_re    (w_ram_re),
        .i_addr  (req_addr[c_AW+1:2]),
        .i_wdata (w_lanes),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d   = r_state_q;
        r_rdata_d   = r_rdata_q;
        r_err_d     = r_err_q;
        r_outport_d = r_outport_q;
        r_funct3_d  = r_funct3_q;
        r_lane_d    = r_lane_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    r_funct3_d = req_funct3;
                    r_lane_d   = req_addr[1:0];
                    if (w_fault) begin
                        r_rdata_d = 32'h0;
                        r_err_d   = 1'b1;
                        r_state_d = RESP;
                    end else if (req_we) begin
                        r_rdata_d = 32'h0;
                        r_err_d   = 1'b0;
                        if (w_is_out) begin
                            r_outport_d = (r_outport_q & ~w_mask) | (w_lanes & w_mask);
                        end
                        r_state_d = RESP;
                    end else if (w_in_ram) begin
                        // Word arrives from the RAM next cycle.
                        r_err_d   = 1'b0;
                        r_state_d = RD_WAIT;
                    end else begin
                        r_rdata_d = load_extend(req_funct3, req_addr[1:0],
                                                w_is_in ? inport : r_outport_q);
                        r_err_d   = 1'b0;
                        r_state_d = RESP;
                    end
                end
            end
            RD_WAIT: begin
                r_rdata_d = load_extend(r_funct3_q, r_lane_q, w_ram_rdata);
                r_err_d   = 1'b0;
                r_state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    r_state_d = IDLE;
                end
            end
            default: begin
                r_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_rdata_q   <= 32'h0;
            r_err_q     <= 1'b0;
            r_outport_q <= 32'h0;
            r_funct3_q  <= 3'b000;
            r_lane_q    <= 2'b00;
        end else begin
            r_state_q   <= r_state_d;
            r_rdata_q   <= r_rdata_d;
            r_err_q     <= r_err_d;
            r_outport_q <= r_outport_d;
            r_funct3_q  <= r_funct3_d;
            r_lane_q    <= r_lane_d;
        end
    end

    assign resp_valid = (r_state_q == RESP);
    assign resp_rdata = r_rdata_q;
    assign resp_err   = r_err_q;
    assign outport    = r_outport_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_responder
// Purpose : Directed self-checking bench for lsu_mem_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_responder;
    import lsu_mem_responder_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] inport;
    logic [31:0] outport;

    int checks   = 0;
    int failures = 0;

    lsu_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .inport     (inport),
        .outport    (outport)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and collects its response; no checking here.
    // Called one time unit after a rising edge with the DUT idle.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat, output logic [31:0] port_after);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        port_after = outport;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        checks++; if (outport !== 32'h0) begin failures++; $display("FAIL reset_outport got=%h exp=0", outport); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        xfer(1'b1, 32'h10, 32'h1234_5678, WORD, rd, er, lat, pa);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL sw_latency got=%0d exp=1", lat); end
        xfer(1'b0, 32'h10, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin failures++; $display("FAIL lw_data got=%h/%b exp=12345678/0", rd, er); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        xfer(1'b1, 32'h13, 32'h0000_00AB, BYTE, rd, er, lat, pa);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sb_err got=%b exp=0", er); end
        xfer(1'b0, 32'h13, 32'h0, BYTE, rd, er, lat, pa);
        checks++; if (rd !== 32'hFFFF_FFAB) begin failures++; $display("FAIL lb got=%h exp=ffffffab", rd); end
        xfer(1'b0, 32'h13, 32'h0, BYTE_U, rd, er, lat, pa);
        checks++; if (rd !== 32'h0000_00AB) begin failures++; $display("FAIL lbu got=%h exp=000000ab", rd); end
        xfer(1'b0, 32'h10, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'hAB34_5678) begin failures++; $display("FAIL lw_after_sb got=%h exp=ab345678", rd); end
        xfer(1'b0, 32'h11, 32'h0, BYTE, rd, er, lat, pa);
        checks++; if (rd !== 32'h0000_0056) begin failures++; $display("FAIL lb_lane1 got=%h exp=00000056", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        xfer(1'b1, 32'h22, 32'h0000_8001, HALF, rd, er, lat, pa);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sh_err got=%b exp=0", er); end
        xfer(1'b0, 32'h22, 32'h0, HALF, rd, er, lat, pa);
        checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", rd); end
        xfer(1'b0, 32'h22, 32'h0, HALF_U, rd, er, lat, pa);
        checks++; if (rd !== 32'h0000_8001) begin failures++; $display("FAIL lhu got=%h exp=00008001", rd); end
        xfer(1'b0, 32'h21, 32'h0, HALF, rd, er, lat, pa);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL lh_misaligned got=%h/%b exp=0/1", rd, er); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL fault_latency got=%0d exp=1", lat); end
        xfer(1'b0, 32'h12, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL lw_misaligned got=%b exp=1", er); end
    endtask

    task automatic test_ports();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        xfer(1'b1, 32'hFFFC, 32'hDEAD_BEEF, WORD, rd, er, lat, pa);
        checks++; if (pa !== 32'hDEAD_BEEF) begin failures++; $display("FAIL outport_after_sw got=%h exp=deadbeef", pa); end
        xfer(1'b0, 32'hFFFC, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'hDEAD_BEEF || lat !== 1) begin failures++; $display("FAIL lw_outport got=%h lat=%0d exp=deadbeef lat=1", rd, lat); end
        inport = 32'h55;
        xfer(1'b0, 32'hFFF8, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'h55 || er !== 1'b0) begin failures++; $display("FAIL lw_inport got=%h/%b exp=00000055/0", rd, er); end
        xfer(1'b1, 32'hFFF8, 32'h1, WORD, rd, er, lat, pa);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL sw_inport got=%h/%b exp=0/1", rd, er); end
        xfer(1'b1, 32'hFFFD, 32'h11, BYTE, rd, er, lat, pa);
        checks++; if (pa !== 32'hDEAD_11EF) begin failures++; $display("FAIL sb_outport got=%h exp=dead11ef", pa); end
        xfer(1'b0, 32'hFFFE, 32'h0, HALF_U, rd, er, lat, pa);
        checks++; if (rd !== 32'h0000_DEAD) begin failures++; $display("FAIL lhu_outport got=%h exp=0000dead", rd); end
        xfer(1'b0, 32'h1000, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL unmapped got=%b exp=1", er); end
        xfer(1'b0, 32'h2000_0010, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL high_bits got=%b exp=1", er); end
        xfer(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat, pa);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL illegal_f3 got=%h/%b exp=0/1", rd, er); end
        xfer(1'b1, 32'h10, 32'hFF, BYTE_U, rd, er, lat, pa);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL store_unsigned got=%b exp=1", er); end
        xfer(1'b0, 32'h10, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'hAB34_5678) begin failures++; $display("FAIL fault_side_effect got=%h exp=ab345678", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        int waited;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = WORD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!resp_valid && waited < 8) begin @(posedge clk); #1; waited++; end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_resp_timeout got=%b exp=1", resp_valid); end
        // A new store waits while the response is held off.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77; req_funct3 = WORD;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hAB34_5678 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=ab345678 rdy=0", i, resp_valid, resp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_handoff got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL bp_next_accept got v=%b e=%b exp v=1 e=0", resp_valid, resp_err); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        xfer(1'b0, 32'h30, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'h77) begin failures++; $display("FAIL bp_store_data got=%h exp=00000077", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic [31:0] pa;
        // Reset while waiting on the RAM.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = WORD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || outport !== 32'h0 || req_ready !== 1'b0) begin failures++; $display("FAIL rst_rdwait got v=%b out=%h rdy=%b exp 0/0/0", resp_valid, outport, req_ready); end
        checks++; if (dut.r_state_q !== IDLE) begin failures++; $display("FAIL rst_rdwait_state got=%0d exp=0", dut.r_state_q); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_rdwait_ready got=%b exp=1", req_ready); end
        // Reset while a response is pending.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hFFFC; req_wdata = 32'h1234; req_funct3 = WORD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || outport !== 32'h1234) begin failures++; $display("FAIL pre_rst_resp got v=%b out=%h exp v=1 out=00001234", resp_valid, outport); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || outport !== 32'h0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp got v=%b out=%h d=%h exp 0/0/0", resp_valid, outport, resp_rdata); end
        checks++; if (dut.r_state_q !== IDLE) begin failures++; $display("FAIL rst_resp_state got=%0d exp=0", dut.r_state_q); end
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'h10, 32'h0, WORD, rd, er, lat, pa);
        checks++; if (rd !== 32'hAB34_5678 || lat !== 2) begin failures++; $display("FAIL ram_after_rst got=%h lat=%0d exp=ab345678 lat=2", rd, lat); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_funct3 = 3'b000; resp_ready = 1'b0; inport = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_ports();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
